hwpe_stream_tcdm_fifo: RTL
==========================

# hwpe_stream_tcdm_fifo

Parametrised TCDM request buffer placed between an HWPE streamer (upstream TCDM master) and the cluster interconnect (downstream TCDM slave). Generalises the fixed 32-bit TCDM port to configurable address and data widths. Decouples upstream request issue from downstream grant stalls through a request FIFO. Bounds the number of in-flight loads and reports idleness for safe clear and flush.

## Interface
- `ADDR_WIDTH`, default 32: address width.
- `DATA_WIDTH`, default 32: data width; must be a multiple of 8.
- `DEPTH`, default 4: request FIFO entries; power of two, at least 2.
- `MAX_OUTSTANDING`, default 2: maximum loads granted downstream but not yet answered; at least 1.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous reset, active-high.
- `clear_i`  in  1  synchronous clear of the request FIFO.
- `in_req_i`  in  1  upstream request.
- `in_gnt_o`  out  1  upstream grant.
- `in_add_i`  in  ADDR_WIDTH  upstream address.
- `in_wen_i`  in  1  1 = load, 0 = store.
- `in_be_i`  in  DATA_WIDTH/8  byte enables.
- `in_data_i`  in  DATA_WIDTH  store data.
- `in_r_data_o`  out  DATA_WIDTH  load data to upstream.
- `in_r_valid_o`  out  1  load response valid to upstream.
- `out_req_o`, `out_gnt_i`, `out_add_o`, `out_wen_o`, `out_be_o`, `out_data_o`, `out_r_data_i`, `out_r_valid_i`: the same signals mirrored on the downstream side, with the same widths.
- `occupancy_o`  out  $clog2(DEPTH)+1  number of queued requests.
- `idle_o`  out  1  FIFO empty and no loads outstanding.

## Operation
- Upstream handshake:
  - `in_gnt_o = !full`. It does not depend on `out_gnt_i`, so there is no combinational gnt path.
  - A request is pushed when `in_req_i && in_gnt_o`.
- Downstream issue:
  - `out_req_o` is asserted when the FIFO is non-empty, except when the head entry is a load and `outstanding == MAX_OUTSTANDING`. Stores are never blocked.
  - `out_*` fields are driven from the FIFO head.
  - The head is popped when `out_req_o && out_gnt_i`.
- Outstanding counter:
  - Increments on a granted load.
  - Decrements on `out_r_valid_i`.
  - Both in the same cycle leaves it unchanged.
  - Width is $clog2(MAX_OUTSTANDING+1).
  - `out_r_valid_i` arriving while the counter is 0 is a protocol error: the counter saturates at 0.
- Responses: in order. No backpressure on the response path, in either direction.
- Simultaneous push and pop:
  - When full: no push, because `in_gnt_o` is 0 that cycle even though a pop is occurring.
  - When neither empty nor full: occupancy is unchanged and the pointers advance.
- Wrap-around: read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is derived from the occupancy counter.
- `clear_i`:
  - Empties the FIFO (pointers and occupancy go to 0) and suppresses push and pop that cycle.
  - Does not reset the outstanding counter. Responses to loads already granted downstream are still forwarded upstream.
  - `idle_o` rises only once those responses have drained.
- `idle_o = (occupancy == 0) && (outstanding == 0)`.

## Timing
- Reset values:
  - `in_gnt_o` = 1 and `out_req_o` = 0.
  - `occupancy_o` = 0 and `idle_o` = 1.
  - `in_r_valid_o` = 0 and `in_r_data_o` = 0.
  - `out_add_o`, `out_wen_o`, `out_be_o` and `out_data_o` are driven from storage; storage resets to 0.
- Request latency: a request granted upstream in cycle N appears on `out_req_o` in cycle N+1 at the earliest. There is no fall-through path.
- Throughput: one request per cycle sustained while downstream grants every cycle.
- Reset mid-operation clears all state asynchronously. Responses arriving after reset are dropped, and the counter stays at 0.

## Configuration
- Macro: `HWPE_STREAM_TCDM_FIFO_RESP_REG_EN`.
- Defined: `in_r_data_o` and `in_r_valid_o` are registered copies of `out_r_data_i` and `out_r_valid_i`, adding 1 cycle of response latency. The register resets to 0.
- Undefined: combinational pass-through with 0 added latency.
- The outstanding counter always uses the downstream `out_r_valid_i`, in both builds.

## Structure
- `hwpe_stream_package` gains:
  - `hwpe_stream_tcdm_req_t` typedef parametrised via localparams: add, wen, be, data.
  - `HWPE_STREAM_TCDM_FIFO_DEPTH_DEFAULT` constant.
- Sub-module `hwpe_stream_tcdm_fifo_buf` contains the storage array, pointers and occupancy counter, with push/pop/clear ports. The top level owns the issue gating, the outstanding counter and the response path.

## Test plan
- **Back-to-back stores, DEPTH=4:** 8 stores to addresses 0x0..0x1C, `out_gnt_i` held 1 → `out_req_o` from cycle 1, all 8 forwarded in order, `in_gnt_o` never drops.
- **Downstream stall:** `out_gnt_i`=0 for 10 cycles with continuous requests → exactly 4 pushed, `in_gnt_o`=0 while full, `occupancy_o`=4. Releasing the grant drains in order.
- **Load limit, MAX_OUTSTANDING=2:** 3 loads with responses delayed 5 cycles → the third load is held off (`out_req_o`=0) until the first `out_r_valid_i`. Response data 0xA5A5A5A5 appears on `in_r_data_o` after 0 or 1 cycles, depending on the macro.
- **Full with simultaneous pop:** FIFO full and `out_gnt_i`=1 → that cycle `in_gnt_o`=0 and occupancy goes to 3; the next cycle `in_gnt_o`=1.
- **Clear with loads in flight:** 2 loads granted downstream, 2 entries queued, `clear_i` pulse → occupancy 0, both responses still forwarded, `idle_o` rises after the second `out_r_valid_i`.
- **Async reset mid-burst:** `rst_i` asserted between clock edges → all outputs take their reset values immediately; a stray `out_r_valid_i` afterwards leaves `idle_o`=1.

Source files
------------

// File: rtl/hwpe_stream_package.sv
// Shared HWPE stream definitions: TCDM request payload layout and
// default sizing constants for the TCDM request FIFO.
package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_TCDM_ADDR_WIDTH = 32;
  localparam int unsigned HWPE_STREAM_TCDM_DATA_WIDTH = 32;
  localparam int unsigned HWPE_STREAM_TCDM_BE_WIDTH   = HWPE_STREAM_TCDM_DATA_WIDTH / 8;

  localparam int unsigned HWPE_STREAM_TCDM_FIFO_DEPTH_DEFAULT           = 4;
  localparam int unsigned HWPE_STREAM_TCDM_FIFO_MAX_OUTSTANDING_DEFAULT = 2;

  // One TCDM request as stored in the request FIFO (wen: 1 = load).
  typedef struct packed {
    logic [HWPE_STREAM_TCDM_ADDR_WIDTH-1:0] add;
    logic                                   wen;
    logic [HWPE_STREAM_TCDM_BE_WIDTH-1:0]   be;
    logic [HWPE_STREAM_TCDM_DATA_WIDTH-1:0] data;
  } hwpe_stream_tcdm_req_t;

endpackage

// File: rtl/hwpe_stream_tcdm_fifo_buf.sv
// Request storage for hwpe_stream_tcdm_fifo: circular buffer with
// read/write pointers and an occupancy counter that defines full/empty.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous flush (pointers and occupancy to 0)
//   push, wdata   write request (ignored when full or clearing)
//   pop           drop head entry (ignored when empty or clearing)
//   rdata_c       head entry, read combinationally from storage
//   occupancy     number of stored entries
//   full_c/empty_c  status derived from occupancy
module hwpe_stream_tcdm_fifo_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata_c,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned PTR_WIDTH = $clog2(DEPTH);
  localparam int unsigned OCC_WIDTH = PTR_WIDTH + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic                 push_en;
  logic                 pop_en;

  assign full_c  = (occupancy == OCC_WIDTH'(DEPTH));
  assign empty_c = (occupancy == '0);
  assign push_en = push & ~full_c;
  assign pop_en  = pop & ~empty_c;
  assign rdata_c = mem[rptr];

  // Storage, pointers (natural wrap) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem       <= '{default: '0};
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
    end else if (clear) begin
      wptr      <= '0;
      rptr      <= '0;
      occupancy <= '0;
    end else begin
      if (push_en) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + PTR_WIDTH'(1);
      end
      if (pop_en) begin
        rptr <= rptr + PTR_WIDTH'(1);
      end
      case ({push_en, pop_en})
        2'b10:   occupancy <= occupancy + OCC_WIDTH'(1);
        2'b01:   occupancy <= occupancy - OCC_WIDTH'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/hwpe_stream_tcdm_fifo.sv
// TCDM request buffer between an HWPE streamer (upstream master) and the
// cluster interconnect (downstream slave). Requests are queued in a FIFO so
// upstream grant never depends on downstream grant; loads in flight are
// bounded by MAX_OUTSTANDING; idle_o flags an empty FIFO with no loads
// awaiting a response.
// Ports:
//   clk_i, rst_i, clear_i          clock, async active-high reset, sync flush
//   in_*                           upstream TCDM slave port
//   out_*                          downstream TCDM master port
//   occupancy_o                    queued requests
//   idle_o                         FIFO empty and no loads outstanding
// Build option: define HWPE_STREAM_TCDM_FIFO_RESP_REG_EN to register the
// response path (one extra cycle of response latency).
module hwpe_stream_tcdm_fifo
  import hwpe_stream_package::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH           = HWPE_STREAM_TCDM_FIFO_DEPTH_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = HWPE_STREAM_TCDM_FIFO_MAX_OUTSTANDING_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    in_req_i,
  output logic                    in_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   in_add_i,
  input  logic                    in_wen_i,
  input  logic [DATA_WIDTH/8-1:0] in_be_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  output logic [DATA_WIDTH-1:0]   in_r_data_o,
  output logic                    in_r_valid_o,
  output logic                    out_req_o,
  input  logic                    out_gnt_i,
  output logic [ADDR_WIDTH-1:0]   out_add_o,
  output logic                    out_wen_o,
  output logic [DATA_WIDTH/8-1:0] out_be_o,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  input  logic [DATA_WIDTH-1:0]   out_r_data_i,
  input  logic                    out_r_valid_i,
  output logic [$clog2(DEPTH):0]  occupancy_o,
  output logic                    idle_o
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  localparam int unsigned REQ_WIDTH = $bits(req_t);

  req_t                 push_req;
  req_t                 head_req;
  logic [REQ_WIDTH-1:0] head_raw;
  logic                 full_c;
  logic                 empty_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 load_blocked_c;
  logic                 inc_c;
  logic                 dec_c;
  logic [CNT_WIDTH-1:0] outstanding;

  // Upstream side: grant depends only on local state.
  assign in_gnt_o = ~full_c;
  assign push_c   = in_req_i & ~full_c;
  assign push_req = '{add: in_add_i, wen: in_wen_i, be: in_be_i, data: in_data_i};

  hwpe_stream_tcdm_fifo_buf #(
    .WIDTH (REQ_WIDTH),
    .DEPTH (DEPTH)
  ) i_buf (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (clear_i),
    .push      (push_c),
    .pop       (pop_c),
    .wdata     (push_req),
    .rdata_c   (head_raw),
    .occupancy (occupancy_o),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

  assign head_req = head_raw;

  // Downstream issue: only a load at the head can be held back.
  assign load_blocked_c = head_req.wen & (outstanding == CNT_WIDTH'(MAX_OUTSTANDING));
  assign out_req_o      = ~empty_c & ~load_blocked_c;
  assign pop_c          = out_req_o & out_gnt_i;
  assign out_add_o      = head_req.add;
  assign out_wen_o      = head_req.wen;
  assign out_be_o       = head_req.be;
  assign out_data_o     = head_req.data;

  // A load granted during a clear is still counted: downstream accepted it
  // and will answer it. A response with nothing outstanding is ignored.
  assign inc_c = pop_c & head_req.wen;
  assign dec_c = out_r_valid_i & (outstanding != '0);

  // Loads granted downstream and not yet answered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({inc_c, dec_c})
        2'b10:   outstanding <= outstanding + CNT_WIDTH'(1);
        2'b01:   outstanding <= outstanding - CNT_WIDTH'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign idle_o = (occupancy_o == '0) && (outstanding == '0);

  // Response path back to the streamer.
`ifdef HWPE_STREAM_TCDM_FIFO_RESP_REG_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_r_valid_o <= 1'b0;
      in_r_data_o  <= '0;
    end else begin
      in_r_valid_o <= out_r_valid_i;
      in_r_data_o  <= out_r_data_i;
    end
  end
`else
  assign in_r_valid_o = out_r_valid_i;
  assign in_r_data_o  = out_r_data_i;
`endif

endmodule
